// File: rtl/store_queue_multi_cdb_if.sv
// Store queue bus bundle: allocation, AGU, CDB, commit, flush, L1 store
// request, load-forwarding query and occupancy status.
//   slave  : store queue side (drives alloc_ready, mem_req_*, fwd_*, status)
//   master : core / L1 side (drives everything else)
// Optional macro STQ_PERF_COUNTERS_EN adds the two perf counter outputs.
interface store_queue_multi_cdb_if #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int STQ_DEPTH     = 8,
  parameter int CDB_PORTS     = 2
);
  localparam int CNT_W = $clog2(STQ_DEPTH + 1);

  logic                               alloc_valid;
  logic                               alloc_ready;
  logic [ROB_TAG_WIDTH-1:0]           alloc_rob_tag;
  logic [XLEN-1:0]                    alloc_data;
  logic                               alloc_data_valid;
  logic                               agu_valid;
  logic [ROB_TAG_WIDTH-1:0]           agu_rob_tag;
  logic [XLEN-1:0]                    agu_addr;
  logic [CDB_PORTS-1:0]               cdb_active;
  logic [CDB_PORTS*ROB_TAG_WIDTH-1:0] cdb_tag;
  logic [CDB_PORTS*XLEN-1:0]          cdb_data;
  logic                               rob_commit;
  logic [ROB_TAG_WIDTH-1:0]           rob_commit_tag;
  logic                               flush;
  logic                               mem_req_valid;
  logic                               mem_req_ready;
  logic [XLEN-1:0]                    mem_req_addr;
  logic [XLEN-1:0]                    mem_req_data;
  logic                               ld_query_valid;
  logic [XLEN-1:0]                    ld_query_addr;
  logic [STQ_DEPTH-1:0]               ld_query_mask;
  logic                               fwd_hit;
  logic [XLEN-1:0]                    fwd_data;
  logic                               fwd_stall;
  logic [STQ_DEPTH-1:0]               store_mask;
  logic [CNT_W-1:0]                   count;
  logic                               full;
  logic                               empty;
`ifdef STQ_PERF_COUNTERS_EN
  logic [31:0]                        perf_alloc_stall_cycles;
  logic [31:0]                        perf_forward_count;
`endif

  modport slave (
`ifdef STQ_PERF_COUNTERS_EN
    output perf_alloc_stall_cycles, perf_forward_count,
`endif
    input  alloc_valid, alloc_rob_tag, alloc_data, alloc_data_valid,
    input  agu_valid, agu_rob_tag, agu_addr,
    input  cdb_active, cdb_tag, cdb_data,
    input  rob_commit, rob_commit_tag, flush,
    input  mem_req_ready,
    input  ld_query_valid, ld_query_addr, ld_query_mask,
    output alloc_ready, mem_req_valid, mem_req_addr, mem_req_data,
    output fwd_hit, fwd_data, fwd_stall,
    output store_mask, count, full, empty
  );

  modport master (
`ifdef STQ_PERF_COUNTERS_EN
    input  perf_alloc_stall_cycles, perf_forward_count,
`endif
    output alloc_valid, alloc_rob_tag, alloc_data, alloc_data_valid,
    output agu_valid, agu_rob_tag, agu_addr,
    output cdb_active, cdb_tag, cdb_data,
    output rob_commit, rob_commit_tag, flush,
    output mem_req_ready,
    output ld_query_valid, ld_query_addr, ld_query_mask,
    input  alloc_ready, mem_req_valid, mem_req_addr, mem_req_data,
    input  fwd_hit, fwd_data, fwd_stall,
    input  store_mask, count, full, empty
  );
endinterface

// File: rtl/store_queue_multi_cdb.sv
// Store queue for the out-of-order LSU. Circular buffer of stores allocated
// in program order; address captured from the AGU, data from the alloc port
// or any CDB port (lowest port wins), committed by ROB tag, drained in order
// to the L1 over a valid/ready handshake. Combinational word-granular
// store-to-load forwarding; flush drops uncommitted entries only.
// Ports: clk, reset (async, active low), bus (store_queue_multi_cdb_if.slave).
// Optional macro STQ_PERF_COUNTERS_EN: saturating perf counters
// perf_alloc_stall_cycles and perf_forward_count on the bus.
module store_queue_multi_cdb #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 5,
  parameter int STQ_DEPTH     = 8,
  parameter int CDB_PORTS     = 2
) (
  input logic                   clk,
  input logic                   reset,
  store_queue_multi_cdb_if.slave bus
);
  localparam int PTR_W = $clog2(STQ_DEPTH);
  localparam int CNT_W = $clog2(STQ_DEPTH + 1);

  typedef struct packed {
    logic                     valid;
    logic [ROB_TAG_WIDTH-1:0] rob_tag;
    logic [XLEN-1:0]          addr;
    logic                     addr_valid;
    logic [XLEN-1:0]          data;
    logic                     data_valid;
    logic                     committed;
  } stq_entry_t;

  stq_entry_t       stq_q   [STQ_DEPTH];
  stq_entry_t       stq_nxt [STQ_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q, head_nxt, tail_nxt;
  logic [CNT_W-1:0] count_q, count_nxt, surv;
  logic             full_c, alloc_fire, drain_fire;
  logic [XLEN:0]    alloc_cdb;

  // {hit, data} of the lowest-index active CDB port carrying tag
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_TAG_WIDTH-1:0]           tag,
    input logic [CDB_PORTS-1:0]               act,
    input logic [CDB_PORTS*ROB_TAG_WIDTH-1:0] tags,
    input logic [CDB_PORTS*XLEN-1:0]          data
  );
    logic [XLEN:0] r;
    r = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--)
      if (act[p] && tags[p*ROB_TAG_WIDTH +: ROB_TAG_WIDTH] == tag)
        r = {1'b1, data[p*XLEN +: XLEN]};
    return r;
  endfunction

  assign full_c     = (count_q == CNT_W'(STQ_DEPTH));
  // full is registered state, so a same-cycle drain never frees a slot
  assign alloc_fire = bus.alloc_valid && !full_c && !bus.flush;
  assign drain_fire = bus.mem_req_valid && bus.mem_req_ready;
  assign alloc_cdb  = cdb_lookup(bus.alloc_rob_tag, bus.cdb_active, bus.cdb_tag, bus.cdb_data);

  assign bus.alloc_ready   = !full_c;
  assign bus.full          = full_c;
  assign bus.empty         = (count_q == '0);
  assign bus.count         = count_q;
  assign bus.mem_req_valid = stq_q[head_q].valid && stq_q[head_q].committed &&
                             stq_q[head_q].addr_valid && stq_q[head_q].data_valid;
  assign bus.mem_req_addr  = stq_q[head_q].addr;
  assign bus.mem_req_data  = stq_q[head_q].data;

  // next-state per entry; later assignments take priority
  always_comb begin
    logic [XLEN:0] hit;
    logic          commit_hit;
    surv = '0;
    hit  = '0;
    for (int i = 0; i < STQ_DEPTH; i++) begin
      stq_nxt[i] = stq_q[i];
      commit_hit = stq_q[i].valid && bus.rob_commit && (stq_q[i].rob_tag == bus.rob_commit_tag);
      if (stq_q[i].valid) begin
        if (bus.agu_valid && !stq_q[i].addr_valid && stq_q[i].rob_tag == bus.agu_rob_tag) begin
          stq_nxt[i].addr       = bus.agu_addr;
          stq_nxt[i].addr_valid = 1'b1;
        end
        hit = cdb_lookup(stq_q[i].rob_tag, bus.cdb_active, bus.cdb_tag, bus.cdb_data);
        if (!stq_q[i].data_valid && hit[XLEN]) begin
          stq_nxt[i].data       = hit[XLEN-1:0];
          stq_nxt[i].data_valid = 1'b1;
        end
        if (commit_hit) stq_nxt[i].committed = 1'b1;
        if (stq_q[i].committed || commit_hit) surv = surv + CNT_W'(1);
      end
      if (bus.flush && !(stq_q[i].committed || commit_hit)) stq_nxt[i].valid = 1'b0;
      if (drain_fire && head_q == PTR_W'(i)) stq_nxt[i].valid = 1'b0;
      if (alloc_fire && tail_q == PTR_W'(i)) begin
        stq_nxt[i].valid      = 1'b1;
        stq_nxt[i].rob_tag    = bus.alloc_rob_tag;
        stq_nxt[i].addr       = '0;
        stq_nxt[i].addr_valid = 1'b0;
        stq_nxt[i].data       = bus.alloc_data_valid ? bus.alloc_data : alloc_cdb[XLEN-1:0];
        stq_nxt[i].data_valid = bus.alloc_data_valid || alloc_cdb[XLEN];
        stq_nxt[i].committed  = 1'b0;
      end
    end
  end

  // The drained head is always a committed survivor, so it leaves the
  // survivor count. Survivors are contiguous from head, which places tail.
  always_comb begin
    logic [CNT_W-1:0] keep;
    keep     = surv - CNT_W'(drain_fire);
    head_nxt = head_q + PTR_W'(drain_fire);
    if (bus.flush) begin
      tail_nxt  = head_nxt + PTR_W'(keep);
      count_nxt = keep;
    end else begin
      tail_nxt  = tail_q + PTR_W'(alloc_fire);
      count_nxt = count_q + CNT_W'(alloc_fire) - CNT_W'(drain_fire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STQ_DEPTH; i++) stq_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < STQ_DEPTH; i++) stq_q[i] <= stq_nxt[i];
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      count_q <= count_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < STQ_DEPTH; i++) bus.store_mask[i] = stq_q[i].valid;
  end

  // Youngest-first search from tail-1; the first considered entry that
  // matches or has an unknown address decides hit vs stall.
  logic             fwd_hit_c, fwd_stall_c, found;
  logic [XLEN-1:0]  fwd_data_c;
  logic [PTR_W-1:0] idx;
  always_comb begin
    fwd_hit_c   = 1'b0;
    fwd_stall_c = 1'b0;
    fwd_data_c  = '0;
    found       = 1'b0;
    idx         = '0;
    for (int k = 0; k < STQ_DEPTH; k++) begin
      idx = tail_q - PTR_W'(k + 1);
      if (!found && stq_q[idx].valid && bus.ld_query_mask[idx]) begin
        if (!stq_q[idx].addr_valid) begin
          found       = 1'b1;
          fwd_stall_c = 1'b1;
        end else if (stq_q[idx].addr[XLEN-1:2] == bus.ld_query_addr[XLEN-1:2]) begin
          found = 1'b1;
          if (stq_q[idx].data_valid) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = stq_q[idx].data;
          end else begin
            fwd_stall_c = 1'b1;
          end
        end
      end
    end
    if (!bus.ld_query_valid) begin
      fwd_hit_c   = 1'b0;
      fwd_stall_c = 1'b0;
      fwd_data_c  = '0;
    end
  end

  assign bus.fwd_hit   = fwd_hit_c;
  assign bus.fwd_stall = fwd_stall_c;
  assign bus.fwd_data  = fwd_data_c;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.ld_query_addr[1:0];

`ifdef STQ_PERF_COUNTERS_EN
  logic [31:0] perf_stall_q, perf_fwd_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_fwd_q   <= '0;
    end else begin
      if (bus.alloc_valid && full_c && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
      if (fwd_hit_c && perf_fwd_q != '1)                   perf_fwd_q   <= perf_fwd_q + 32'd1;
    end
  end
  assign bus.perf_alloc_stall_cycles = perf_stall_q;
  assign bus.perf_forward_count      = perf_fwd_q;
`endif
endmodule

// File: tb/tb_store_queue_multi_cdb.sv
// Directed bench for store_queue_multi_cdb: an 8-entry instance for fill,
// CDB capture, drain hold, flush and forwarding, and a 4-entry instance for
// pointer wrap under back-to-back alloc/drain. L1 requests go through a
// scoreboard queue popped by per-instance monitors.
module tb_store_queue_multi_cdb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_queue_multi_cdb_if #(.STQ_DEPTH(8)) b8 ();
  store_queue_multi_cdb_if #(.STQ_DEPTH(4)) b4 ();

  store_queue_multi_cdb #(.XLEN(32), .ROB_TAG_WIDTH(5), .STQ_DEPTH(8), .CDB_PORTS(2))
    dut8 (.clk(clk), .reset(reset), .bus(b8));
  store_queue_multi_cdb #(.XLEN(32), .ROB_TAG_WIDTH(5), .STQ_DEPTH(4), .CDB_PORTS(2))
    dut4 (.clk(clk), .reset(reset), .bus(b4));

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } req_t;
  req_t q8[$], q4[$];
  req_t e8, e4;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle8();
    b8.alloc_valid = 0; b8.alloc_rob_tag = '0; b8.alloc_data = '0; b8.alloc_data_valid = 0;
    b8.agu_valid = 0; b8.agu_rob_tag = '0; b8.agu_addr = '0;
    b8.cdb_active = '0; b8.cdb_tag = '0; b8.cdb_data = '0;
    b8.rob_commit = 0; b8.rob_commit_tag = '0; b8.flush = 0;
    b8.ld_query_valid = 0; b8.ld_query_addr = '0; b8.ld_query_mask = '0;
  endtask

  task automatic idle4();
    b4.alloc_valid = 0; b4.alloc_rob_tag = '0; b4.alloc_data = '0; b4.alloc_data_valid = 0;
    b4.agu_valid = 0; b4.agu_rob_tag = '0; b4.agu_addr = '0;
    b4.cdb_active = '0; b4.cdb_tag = '0; b4.cdb_data = '0;
    b4.rob_commit = 0; b4.rob_commit_tag = '0; b4.flush = 0;
    b4.ld_query_valid = 0; b4.ld_query_addr = '0; b4.ld_query_mask = '0;
  endtask

  task automatic alloc8(input int tag, input logic [31:0] data, input logic dv);
    b8.alloc_valid = 1; b8.alloc_rob_tag = 5'(tag); b8.alloc_data = data; b8.alloc_data_valid = dv;
    tick();
    b8.alloc_valid = 0; b8.alloc_data_valid = 0;
  endtask

  task automatic agu8(input int tag, input logic [31:0] addr);
    b8.agu_valid = 1; b8.agu_rob_tag = 5'(tag); b8.agu_addr = addr;
    tick();
    b8.agu_valid = 0;
  endtask

  task automatic commit8(input int tag);
    b8.rob_commit = 1; b8.rob_commit_tag = 5'(tag);
    tick();
    b8.rob_commit = 0;
  endtask

  task automatic fwd8(input string name, input logic qv, input logic [31:0] addr, input logic [7:0] mask,
                      input logic hit, input logic stall, input logic [31:0] data);
    b8.ld_query_valid = qv; b8.ld_query_addr = addr; b8.ld_query_mask = mask;
    #1;
    chk({name, "_hit"}, b8.fwd_hit, hit);
    chk({name, "_stall"}, b8.fwd_stall, stall);
    chk({name, "_data"}, b8.fwd_data, data);
    b8.ld_query_valid = 0; b8.ld_query_mask = '0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && b8.mem_req_valid && b8.mem_req_ready) begin
      if (q8.size() == 0) begin
        n_chk++;
        $display("FAIL drain8_unexpected: got addr 0x%0h want no request", b8.mem_req_addr);
      end else begin
        e8 = q8.pop_front();
        chk("drain8_addr", b8.mem_req_addr, e8.addr);
        chk("drain8_data", b8.mem_req_data, e8.data);
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && b4.mem_req_valid && b4.mem_req_ready) begin
      if (q4.size() == 0) begin
        n_chk++;
        $display("FAIL drain4_unexpected: got addr 0x%0h want no request", b4.mem_req_addr);
      end else begin
        e4 = q4.pop_front();
        chk("drain4_addr", b4.mem_req_addr, e4.addr);
        chk("drain4_data", b4.mem_req_data, e4.data);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0;
    idle8(); idle4();
    b8.mem_req_ready = 0; b4.mem_req_ready = 0;
    b8.ld_query_valid = 1; b8.ld_query_mask = 8'hFF;
    #12;
    chk("rst_empty", b8.empty, 1);
    chk("rst_full", b8.full, 0);
    chk("rst_count", b8.count, 0);
    chk("rst_ready", b8.alloc_ready, 1);
    chk("rst_memv", b8.mem_req_valid, 0);
    chk("rst_fwdhit", b8.fwd_hit, 0);
    chk("rst_fwdstall", b8.fwd_stall, 0);
    chk("rst_mask", b8.store_mask, 0);
    b8.ld_query_valid = 0; b8.ld_query_mask = '0;
    @(negedge clk); reset = 1;
    tick();

    // fill: tag 3 has no data yet
    for (int t = 1; t <= 8; t++)
      alloc8(t, (t == 1) ? 32'h11 : (t == 2) ? 32'h22 : 32'h1000 + t, t != 3);
    chk("fill_count", b8.count, 8);
    chk("fill_full", b8.full, 1);
    chk("fill_ready", b8.alloc_ready, 0);
    chk("fill_mask", b8.store_mask, 8'hFF);
    alloc8(9, 32'h9, 1);
    chk("over_count", b8.count, 8);
`ifdef STQ_PERF_COUNTERS_EN
    chk("perf_stall", b8.perf_alloc_stall_cycles, 1);
`endif

    // CDB: port 0 carries an unknown tag, port 1 tag 3
    b8.cdb_active = 2'b11; b8.cdb_tag = {5'd3, 5'd9}; b8.cdb_data = {32'hDEADBEEF, 32'h99999999};
    tick();
    b8.cdb_active = '0;
    agu8(1, 32'h100); agu8(2, 32'h104); agu8(3, 32'h108);
    commit8(1);
    for (int h = 0; h < 3; h++) begin
      chk($sformatf("hold%0d_valid", h), b8.mem_req_valid, 1);
      chk($sformatf("hold%0d_addr", h), b8.mem_req_addr, 32'h100);
      chk($sformatf("hold%0d_data", h), b8.mem_req_data, 32'h11);
      if (h < 2) tick();
    end
    q8.push_back('{addr: 32'h100, data: 32'h11});
    b8.mem_req_ready = 1; tick(); b8.mem_req_ready = 0;
    chk("drain1_count", b8.count, 7);
    chk("drain1_mask", b8.store_mask, 8'hFE);
    chk("drain1_memv", b8.mem_req_valid, 0);
    commit8(2); commit8(3);
    q8.push_back('{addr: 32'h104, data: 32'h22});
    q8.push_back('{addr: 32'h108, data: 32'hDEADBEEF});
    b8.mem_req_ready = 1; tick(); tick(); b8.mem_req_ready = 0;
    chk("drain3_count", b8.count, 5);
    chk("drain3_mask", b8.store_mask, 8'hF8);

    // flush: tags 4,5 committed, tag 6 commits in the flush cycle, alloc dropped
    commit8(4); commit8(5);
    b8.flush = 1; b8.rob_commit = 1; b8.rob_commit_tag = 5'd6;
    b8.alloc_valid = 1; b8.alloc_rob_tag = 5'd20; b8.alloc_data = 32'h20; b8.alloc_data_valid = 1;
    tick();
    b8.flush = 0; b8.rob_commit = 0; b8.alloc_valid = 0; b8.alloc_data_valid = 0;
    chk("flush_count", b8.count, 3);
    chk("flush_mask", b8.store_mask, 8'h38);
    chk("flush_memv", b8.mem_req_valid, 0);
    alloc8(10, 32'hA, 1);
    chk("flush_tail", b8.store_mask, 8'h78);
    alloc8(11, 32'hB, 1);
    agu8(10, 32'h200); agu8(11, 32'h200);

    fwd8("fwd_young", 1, 32'h200, 8'hC0, 1, 0, 32'hB);
    fwd8("fwd_word",  1, 32'h202, 8'hC0, 1, 0, 32'hB);
    fwd8("fwd_older", 1, 32'h200, 8'h40, 1, 0, 32'hA);
    fwd8("fwd_miss",  1, 32'h204, 8'hC0, 0, 0, 32'h0);
    fwd8("fwd_unk",   1, 32'h204, 8'hE0, 0, 1, 32'h0);
    fwd8("fwd_noq",   0, 32'h200, 8'hC0, 0, 0, 32'h0);
    alloc8(12, 32'h0, 0);
    agu8(12, 32'h200);
    fwd8("fwd_nodata", 1, 32'h200, 8'hC1, 0, 1, 32'h0);
    b8.cdb_active = 2'b11; b8.cdb_tag = {5'd12, 5'd12}; b8.cdb_data = {32'h55555555, 32'h12120000};
    tick();
    b8.cdb_active = '0;
    fwd8("fwd_cdbprio", 1, 32'h200, 8'hC1, 1, 0, 32'h12120000);
    chk("end8_count", b8.count, 6);

    // 4-entry wrap: alloc tag c, address+commit tag c-1, L1 always ready
    b4.mem_req_ready = 1;
    for (int c = 1; c <= 13; c++) begin
      b4.alloc_valid = (c <= 12); b4.alloc_rob_tag = 5'(c);
      b4.alloc_data = 32'hC0DE0000 + c; b4.alloc_data_valid = 1;
      if (c <= 12) q4.push_back('{addr: 32'h1000 + 4 * c, data: 32'hC0DE0000 + c});
      b4.agu_valid = (c >= 2); b4.agu_rob_tag = 5'(c - 1); b4.agu_addr = 32'h1000 + 4 * (c - 1);
      b4.rob_commit = (c >= 2); b4.rob_commit_tag = 5'(c - 1);
      tick();
      if (c >= 2 && c <= 12) chk($sformatf("wrap_count%0d", c), b4.count, 2);
    end
    idle4();
    tick(); tick(); tick();
    chk("wrap_empty", b4.empty, 1);
    chk("wrap_count_end", b4.count, 0);
    chk("sb8_left", q8.size(), 0);
    chk("sb4_left", q4.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/store_queue_multi_cdb.md
Name: store_queue_multi_cdb

Overview:
- Parametrised store queue for the out-of-order LSU.
- Circular buffer of stores that:
  - allocates in program order,
  - captures address from the AGU and data from one of several CDB ports,
  - marks entries committed by ROB tag,
  - drains committed stores to the L1 through a valid/ready handshake.
- Provides combinational store-to-load forwarding and flush recovery that keeps committed entries.

Parameters:
- XLEN, 32, data/address width
- ROB_TAG_WIDTH, 5, ROB tag width
- STQ_DEPTH, 8, number of entries (power of two, at least 2)
- CDB_PORTS, 2, number of common data bus broadcast ports

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- alloc_valid  in  1  allocate entry at tail
- alloc_ready  out  1  equals !full
- alloc_rob_tag  in  ROB_TAG_WIDTH  tag stored in new entry
- alloc_data  in  XLEN  store data if known
- alloc_data_valid  in  1  alloc_data is valid
- agu_valid  in  1  address result valid
- agu_rob_tag  in  ROB_TAG_WIDTH  tag of address result
- agu_addr  in  XLEN  computed address
- cdb_active  in  CDB_PORTS  per-port broadcast valid
- cdb_tag  in  CDB_PORTS*ROB_TAG_WIDTH  packed tags, port 0 in LSBs
- cdb_data  in  CDB_PORTS*XLEN  packed data
- rob_commit  in  1  commit strobe
- rob_commit_tag  in  ROB_TAG_WIDTH  committing tag
- flush  in  1  discard all uncommitted entries
- mem_req_valid  out  1  store request to L1
- mem_req_ready  in  1  L1 accepts request
- mem_req_addr  out  XLEN  store address
- mem_req_data  out  XLEN  store data
- ld_query_valid  in  1  forwarding lookup
- ld_query_addr  in  XLEN  load address
- ld_query_mask  in  STQ_DEPTH  entries older than the load
- fwd_hit  out  1  forward fwd_data
- fwd_data  out  XLEN  forwarded data
- fwd_stall  out  1  load must wait
- store_mask  out  STQ_DEPTH  valid-entry bitmap, captured by the LDQ at load allocation
- count  out  $clog2(STQ_DEPTH+1)  occupied entries
- full  out  1  count==STQ_DEPTH
- empty  out  1  count==0

Behaviour:
- Entry fields: valid, rob_tag, addr, addr_valid, data, data_valid, committed.
- Reset (asynchronous, active-low): all entries invalid; head=tail=0; count=0; empty=1; full=0; mem_req_valid=0; fwd_hit=0; fwd_stall=0; store_mask=0.
- Allocation:
  - Accepted when alloc_valid && !full. full is taken from registered state, so allocation is rejected when full even if a drain occurs in the same cycle.
  - Writes the entry at tail, then tail=tail+1 mod STQ_DEPTH.
  - data_valid is set if alloc_data_valid is set, or if any CDB port matches alloc_rob_tag in the same cycle (CDB data is captured in that case).
- AGU: each valid entry with rob_tag==agu_rob_tag and !addr_valid latches the address and sets addr_valid on the next edge.
- CDB:
  - Each valid entry with !data_valid captures data from a port with cdb_active set and a matching tag.
  - If several ports match, the lowest port index wins.
- Commit: the valid entry with matching tag sets committed. A tag that matches no entry is ignored.
- Drain:
  - mem_req_valid is combinational: head entry valid && committed && addr_valid && data_valid.
  - On mem_req_valid && mem_req_ready, the head entry is invalidated and head increments.
  - At most one drain per cycle. The request holds stable while ready is low.
- Flush:
  - Clears every entry that is not committed. An entry whose commit arrives in the same cycle survives.
  - Sets tail=head+number of surviving committed entries, mod STQ_DEPTH. Committed entries are contiguous from head.
  - An allocation in the same cycle as flush is dropped. A drain in the same cycle as flush proceeds.
- count tracks simultaneous alloc and drain: unchanged when both occur.
- Forwarding (combinational, word granularity, addr[XLEN-1:2]):
  - Considered entries are those with valid && ld_query_mask[i].
  - Search runs from tail-1 toward head. The first considered entry that matches, or that has !addr_valid, decides the result:
    - matching address and data_valid: fwd_hit=1, fwd_data=entry data;
    - otherwise (matching without data, or unknown address): fwd_stall=1.
  - With no deciding entry, or with ld_query_valid=0, both outputs are 0. fwd_hit and fwd_stall are never both 1.
- Wrap-around: head and tail wrap independently; full/empty come from count, not pointer equality.

Optional Feature:
- Macro: STQ_PERF_COUNTERS_EN.
- When defined, adds two outputs, each a 32-bit saturating counter cleared by reset:
  - perf_alloc_stall_cycles: increments on every cycle with alloc_valid && full.
  - perf_forward_count: increments on every cycle with fwd_hit.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then fill 8 entries (tags 1..8) with DEPTH=8 -> full=1, alloc_ready=0, count=8; a ninth alloc is ignored and perf_alloc_stall_cycles=1.
- Tag 3 allocated without data; port 1 broadcasts tag 3 data 0xDEADBEEF while port 0 broadcasts tag 9 -> entry data_valid=1, data=0xDEADBEEF.
- Entry tag 1 has addr 0x100, data 0x11 and is committed; mem_req_ready is held low for 2 cycles -> mem_req_valid is stable with addr 0x100 and data 0x11; ready high -> head advances and count drops by 1.
- Two older stores to 0x200 (data 0xA then 0xB), query 0x200 with both mask bits set -> fwd_hit=1, fwd_data=0xB; clearing the younger store's data_valid -> fwd_stall=1, fwd_hit=0.
- Entries tags 1..5 with tags 1-2 committed; flush asserted with commit of tag 3 in the same cycle -> 3 entries remain, tail=head+3, alloc in that cycle dropped.
- DEPTH=4: alloc and drain repeated 10 times -> pointers wrap correctly, count stays constant, and requests come out in allocation order.
